// File: rtl/vga_pkg.sv
// Shared timing constants, counter type and sync/blank flag bundle for the VGA
// timing path.
package vga_pkg;

    localparam int H_VISIBLE  = 640;
    localparam int H_FRONT    = 16;
    localparam int H_SYNC     = 96;
    localparam int H_BACK     = 48;
    localparam int V_VISIBLE  = 480;
    localparam int V_FRONT    = 10;
    localparam int V_SYNC     = 2;
    localparam int V_BACK     = 33;
    localparam int PIPE_DELAY = 2;

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC - 1;

    localparam int CNT_W = 10;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank;
        logic frame_start;
    } vga_flags_t;

    localparam vga_flags_t FLAGS_RESET = '{hs: 1'b1, vs: 1'b1, blank: 1'b0, frame_start: 1'b0};

    function automatic logic in_window(input cnt_t v, input cnt_t lo, input cnt_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Enabled shift register that lines the sync/blank flags up with the renderers'
// ROM->colour-register pipeline; DEPTH=0 is a plain wire.
module vga_sync_delay #(
    parameter int               WIDTH     = 3,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst, en};
            assign dout = din;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_q [DEPTH];
            logic [WIDTH-1:0] stage_d [DEPTH];

            always_comb begin
                stage_d = stage_q;
                if (en) begin
                    stage_d[0] = din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_d[i] = stage_q[i-1];
                    end
                end
            end

            // NOTE: the stages are reset too, so hs_d/vs_d/blank_d go inactive together with hs/vs/blank.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= RESET_VAL;
                    end
                end else begin
                    stage_q <= stage_d;
                end
            end

            assign dout = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timebase: clk/2 pixel clock, DrawX/DrawY counters, sync and
// blank flags, a start-of-frame strobe and pipeline-delayed sync/blank copies.
module vga_timing_gen
    import vga_pkg::cnt_t;
    import vga_pkg::vga_flags_t;
    import vga_pkg::FLAGS_RESET;
    import vga_pkg::in_window;
#(
    parameter int H_VISIBLE  = vga_pkg::H_VISIBLE,
    parameter int H_FRONT    = vga_pkg::H_FRONT,
    parameter int H_SYNC     = vga_pkg::H_SYNC,
    parameter int H_BACK     = vga_pkg::H_BACK,
    parameter int V_VISIBLE  = vga_pkg::V_VISIBLE,
    parameter int V_FRONT    = vga_pkg::V_FRONT,
    parameter int V_SYNC     = vga_pkg::V_SYNC,
    parameter int V_BACK     = vga_pkg::V_BACK,
    parameter int PIPE_DELAY = vga_pkg::PIPE_DELAY
) (
    input  logic       clk,
    input  logic       reset,
    output logic       vga_clk,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       hs_d,
    output logic       vs_d,
    output logic       blank_d,
    output logic       frame_start
);

    localparam cnt_t H_MAX    = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam cnt_t V_MAX    = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam cnt_t H_VIS    = cnt_t'(H_VISIBLE);
    localparam cnt_t V_VIS    = cnt_t'(V_VISIBLE);
    localparam cnt_t HS_START = cnt_t'(H_VISIBLE + H_FRONT);
    localparam cnt_t HS_END   = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam cnt_t VS_START = cnt_t'(V_VISIBLE + V_FRONT);
    localparam cnt_t VS_END   = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic       vga_clk_q, vga_clk_d;
    logic       pix_en;
    cnt_t       x_q, x_d;
    cnt_t       y_q, y_d;
    vga_flags_t flags_q, flags_d;
    logic [2:0] sync_dly;

    // Counters move on the vga_clk falling edge so renderers see stable values on its rise.
    assign pix_en = vga_clk_q;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        vga_clk_d = ~vga_clk_q;
        x_d       = x_q;
        y_d       = y_q;
        flags_d   = flags_q;
        if (pix_en) begin
            if (x_q == H_MAX) begin
                x_d = '0;
                y_d = (y_q == V_MAX) ? '0 : y_q + cnt_t'(1);
            end else begin
                x_d = x_q + cnt_t'(1);
            end
            // Flags come from the next count so they stay coherent with DrawX/DrawY.
            flags_d.blank       = (x_d < H_VIS) && (y_d < V_VIS);
            flags_d.hs          = ~in_window(x_d, HS_START, HS_END);
            flags_d.vs          = ~in_window(y_d, VS_START, VS_END);
            flags_d.frame_start = (x_d == '0) && (y_d == '0);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the next state is built above.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vga_clk_q <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            flags_q   <= FLAGS_RESET;
        end else begin
            vga_clk_q <= vga_clk_d;
            x_q       <= x_d;
            y_q       <= y_d;
            flags_q   <= flags_d;
        end
    end

    vga_sync_delay #(
        .WIDTH     (3),
        .DEPTH     (PIPE_DELAY),
        .RESET_VAL (3'b110)
    ) u_sync_delay (
        .clk  (clk),
        .rst  (reset),
        .en   (pix_en),
        .din  ({flags_q.hs, flags_q.vs, flags_q.blank}),
        .dout (sync_dly)
    );

    assign vga_clk     = vga_clk_q;
    assign DrawX       = x_q;
    assign DrawY       = y_q;
    assign blank       = flags_q.blank;
    assign hs          = flags_q.hs;
    assign vs          = flags_q.vs;
    assign frame_start = flags_q.frame_start;
    assign {hs_d, vs_d, blank_d} = sync_dly;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: one default-timing instance plus two
// shrunken-raster instances (PIPE_DELAY 2 and 0) so whole frames fit in a short run.
module tb_vga_timing_gen;

    typedef logic [31:0] val_t;

    typedef struct packed {
        int ht; int vt; int hv; int vv; int hs0; int hs1; int vs0; int vs1; int d;
    } cfg_t;

    typedef struct packed {
        val_t vclk; val_t x; val_t y; val_t hs; val_t vs; val_t blank; val_t fs;
        val_t hsd; val_t vsd; val_t blankd;
    } rec_t;

    localparam cfg_t CF = '{ht: 800, vt: 525, hv: 640, vv: 480, hs0: 656, hs1: 751,
                            vs0: 490, vs1: 491, d: 2};
    localparam cfg_t CS = '{ht: 25, vt: 19, hv: 16, vv: 12, hs0: 18, hs1: 21,
                            vs0: 14, vs1: 15, d: 2};
    localparam cfg_t CZ = '{ht: 25, vt: 19, hv: 16, vv: 12, hs0: 18, hs1: 21,
                            vs0: 14, vs1: 15, d: 0};

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       f_vclk, f_blank, f_hs, f_vs, f_hs_d, f_vs_d, f_blank_d, f_fs;
    logic [9:0] f_x, f_y;
    logic       s_vclk, s_blank, s_hs, s_vs, s_hs_d, s_vs_d, s_blank_d, s_fs;
    logic [9:0] s_x, s_y;
    logic       z_vclk, z_blank, z_hs, z_vs, z_hs_d, z_vs_d, z_blank_d, z_fs;
    logic [9:0] z_x, z_y;

    vga_timing_gen dut_full (
        .clk(clk), .reset(reset), .vga_clk(f_vclk), .DrawX(f_x), .DrawY(f_y),
        .blank(f_blank), .hs(f_hs), .vs(f_vs), .hs_d(f_hs_d), .vs_d(f_vs_d),
        .blank_d(f_blank_d), .frame_start(f_fs)
    );

    vga_timing_gen #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
        .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .PIPE_DELAY(2)
    ) dut_small (
        .clk(clk), .reset(reset), .vga_clk(s_vclk), .DrawX(s_x), .DrawY(s_y),
        .blank(s_blank), .hs(s_hs), .vs(s_vs), .hs_d(s_hs_d), .vs_d(s_vs_d),
        .blank_d(s_blank_d), .frame_start(s_fs)
    );

    vga_timing_gen #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
        .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .PIPE_DELAY(0)
    ) dut_zero (
        .clk(clk), .reset(reset), .vga_clk(z_vclk), .DrawX(z_x), .DrawY(z_y),
        .blank(z_blank), .hs(z_hs), .vs(z_vs), .hs_d(z_hs_d), .vs_d(z_vs_d),
        .blank_d(z_blank_d), .frame_start(z_fs)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    int   e_cnt   = 0;
    int   cnt_hs  = 0;
    int   cnt_vs  = 0;
    int   cnt_fs  = 0;
    rec_t sb[$];

    task automatic check(input string tag, input val_t got, input val_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (clk edge %0d since release)", tag, got, exp, e_cnt);
        end
    endtask

    // Flags a raster position p pixels after reset release should show; p<=0 is the reset state.
    function automatic void flags_at(input cfg_t c, input int p, output val_t hs, output val_t vs,
                                     output val_t blank, output val_t fs);
        int x, y;
        if (p <= 0) begin
            hs = 1; vs = 1; blank = 0; fs = 0;
            return;
        end
        x     = p % c.ht;
        y     = (p / c.ht) % c.vt;
        hs    = (x >= c.hs0 && x <= c.hs1) ? 0 : 1;
        vs    = (y >= c.vs0 && y <= c.vs1) ? 0 : 1;
        blank = (x < c.hv && y < c.vv) ? 1 : 0;
        fs    = (x == 0 && y == 0) ? 1 : 0;
    endfunction

    function automatic rec_t model(input cfg_t c, input int e);
        rec_t r;
        val_t unused_fs;
        int   p;
        p      = e / 2;
        r.vclk = val_t'(e % 2);
        r.x    = val_t'(p % c.ht);
        r.y    = val_t'((p / c.ht) % c.vt);
        flags_at(c, p, r.hs, r.vs, r.blank, r.fs);
        flags_at(c, p - c.d, r.hsd, r.vsd, r.blankd, unused_fs);
        return r;
    endfunction

    function automatic rec_t act_f();
        rec_t r;
        r.vclk = val_t'(f_vclk); r.x = val_t'(f_x); r.y = val_t'(f_y);
        r.hs = val_t'(f_hs); r.vs = val_t'(f_vs); r.blank = val_t'(f_blank); r.fs = val_t'(f_fs);
        r.hsd = val_t'(f_hs_d); r.vsd = val_t'(f_vs_d); r.blankd = val_t'(f_blank_d);
        return r;
    endfunction

    function automatic rec_t act_s();
        rec_t r;
        r.vclk = val_t'(s_vclk); r.x = val_t'(s_x); r.y = val_t'(s_y);
        r.hs = val_t'(s_hs); r.vs = val_t'(s_vs); r.blank = val_t'(s_blank); r.fs = val_t'(s_fs);
        r.hsd = val_t'(s_hs_d); r.vsd = val_t'(s_vs_d); r.blankd = val_t'(s_blank_d);
        return r;
    endfunction

    function automatic rec_t act_z();
        rec_t r;
        r.vclk = val_t'(z_vclk); r.x = val_t'(z_x); r.y = val_t'(z_y);
        r.hs = val_t'(z_hs); r.vs = val_t'(z_vs); r.blank = val_t'(z_blank); r.fs = val_t'(z_fs);
        r.hsd = val_t'(z_hs_d); r.vsd = val_t'(z_vs_d); r.blankd = val_t'(z_blank_d);
        return r;
    endfunction

    task automatic cmp_rec(input string tag, input rec_t exp, input rec_t act);
        check({tag, ".vga_clk"}, act.vclk, exp.vclk);
        check({tag, ".DrawX"}, act.x, exp.x);
        check({tag, ".DrawY"}, act.y, exp.y);
        check({tag, ".hs"}, act.hs, exp.hs);
        check({tag, ".vs"}, act.vs, exp.vs);
        check({tag, ".blank"}, act.blank, exp.blank);
        check({tag, ".frame_start"}, act.fs, exp.fs);
        check({tag, ".hs_d"}, act.hsd, exp.hsd);
        check({tag, ".vs_d"}, act.vsd, exp.vsd);
        check({tag, ".blank_d"}, act.blankd, exp.blankd);
    endtask

    // Push the expectation for the coming clk edge, then pop it against the DUTs on the falling edge.
    task automatic step();
        int p;
        e_cnt++;
        sb.push_back(model(CF, e_cnt));
        sb.push_back(model(CS, e_cnt));
        sb.push_back(model(CZ, e_cnt));
        @(posedge clk);
        @(negedge clk);
        cmp_rec("full", sb.pop_front(), act_f());
        cmp_rec("small", sb.pop_front(), act_s());
        cmp_rec("zero", sb.pop_front(), act_z());
        p = e_cnt / 2;
        if (e_cnt % 2 == 0) begin
            if (p < CF.ht && f_hs == 1'b0) cnt_hs++;
            if (p >= CS.ht * CS.vt && p < 2 * CS.ht * CS.vt && s_vs == 1'b0) cnt_vs++;
            if (s_fs == 1'b1) cnt_fs++;
        end
    endtask

    task automatic check_reset_values(input string tag);
        rec_t r0;
        r0 = model(CF, 0);
        cmp_rec({tag, ".full"}, r0, act_f());
        cmp_rec({tag, ".small"}, r0, act_s());
        cmp_rec({tag, ".zero"}, r0, act_z());
    endtask

    initial begin
        int   found;
        rec_t m;

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;
        e_cnt = 0;

        repeat (2000) step();
        check("line0_hs_low_pixels", val_t'(cnt_hs), 96);
        check("frame_vs_low_pixels", val_t'(cnt_vs), 50);
        check("frame_start_pulses", val_t'(cnt_fs), 2);

        // Walk the small raster to the last HS-low pixel of a mid-frame line.
        found = 0;
        for (int i = 0; i < 1000 && found == 0; i++) begin
            step();
            m = model(CS, e_cnt);
            if (m.x == 21 && m.y == 7 && e_cnt % 2 == 0) found = 1;
        end
        check("seek_mid_frame", val_t'(found), 1);
        check("pre_reset.hs", val_t'(s_hs), 0);
        check("pre_reset.hs_d", val_t'(s_hs_d), 0);

        #1 reset = 1'b1;
        #1;
        sb.delete();
        check_reset_values("async_reset");

        @(negedge clk);
        check_reset_values("held_reset");
        reset = 1'b0;
        e_cnt = 0;
        cnt_fs = 0;
        repeat (60) step();
        check("restart_frame_start_pulses", val_t'(cnt_fs), 0);
        check("scoreboard_drained", val_t'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
